// File: rtl/ram_access_ctrl_pkg.sv
// Shared encodings and store-side lane helpers for the RAM access controller.
package ram_access_ctrl_pkg;

  localparam logic [1:0] SIZE_BYTE = 2'd0;
  localparam logic [1:0] SIZE_HALF = 2'd1;
  localparam logic [1:0] SIZE_WORD = 2'd2;
  localparam logic [1:0] SIZE_ILL  = 2'd3;

  typedef enum logic {
    ST_IDLE    = 1'b0,
    ST_RD_WAIT = 1'b1
  } state_t;

  typedef enum logic {
    PORT_CORE = 1'b0,
    PORT_DBG  = 1'b1
  } port_t;

  // Everything needed to format and route the read word once it returns.
  typedef struct packed {
    port_t      port;
    logic [1:0] size;
    logic       uns;
    logic [1:0] offset;
  } rd_ctx_t;

  function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] offset);
    case (size)
      SIZE_BYTE: return 1'b0;
      SIZE_HALF: return offset[0];
      SIZE_WORD: return offset != 2'b00;
      default:   return 1'b1;
    endcase
  endfunction

  function automatic logic [3:0] lane_mask(input logic [1:0] size, input logic [1:0] offset);
    case (size)
      SIZE_BYTE: return 4'b0001 << offset;
      SIZE_HALF: return offset[1] ? 4'b1100 : 4'b0011;
      default:   return 4'b1111;
    endcase
  endfunction

  function automatic logic [31:0] store_data(input logic [1:0] size, input logic [31:0] wdata);
    case (size)
      SIZE_BYTE: return {4{wdata[7:0]}};
      SIZE_HALF: return {2{wdata[15:0]}};
      default:   return wdata;
    endcase
  endfunction

endpackage

// File: rtl/ram_access_ctrl_load_align.sv
// Purpose: pick the addressed byte/half out of a RAM word and sign/zero-extend it to 32 bits.
// Latency: purely combinational.
// Backpressure: none; the result is consumed by the owner's capture register.
module ram_access_ctrl_load_align
  import ram_access_ctrl_pkg::*;
(
  input  logic [31:0] dout,
  input  logic [1:0]  offset,
  input  logic [1:0]  size,
  input  logic        is_unsigned,
  output logic [31:0] data
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    case (offset)
      2'd0:    byte_sel = dout[7:0];
      2'd1:    byte_sel = dout[15:8];
      2'd2:    byte_sel = dout[23:16];
      default: byte_sel = dout[31:24];
    endcase
    half_sel = offset[1] ? dout[31:16] : dout[15:0];
  end

  always_comb begin
    case (size)
      SIZE_BYTE: data = {{24{~is_unsigned & byte_sel[7]}}, byte_sel};
      SIZE_HALF: data = {{16{~is_unsigned & half_sel[15]}}, half_sel};
      default:   data = dout;
    endcase
  end

endmodule

// File: rtl/ram_access_ctrl.sv
// Purpose: arbitrate core/debug ports onto a single-port RAM with byte-lane stores and extended loads.
// Latency: writes and traps are accepted in one cycle; load data pulses two cycles after the ack.
// Backpressure: one read outstanding; acks are withheld while a read is in flight, loser holds req.
module ram_access_ctrl
  import ram_access_ctrl_pkg::*;
#(
  parameter int ADDR_WIDTH   = 12,
  parameter bit DBG_PRIORITY = 1'b1
) (
  input  logic                  clk,
  input  logic                  reset_n,

  input  logic                  core_req,
  input  logic                  core_we,
  input  logic [ADDR_WIDTH+1:0] core_addr,
  input  logic [1:0]            core_size,
  input  logic                  core_unsigned,
  input  logic [31:0]           core_wdata,
  output logic                  core_ack,
  output logic [31:0]           core_rdata,
  output logic                  core_rvalid,
  output logic                  core_misaligned,

  input  logic                  dbg_req,
  input  logic                  dbg_we,
  input  logic [ADDR_WIDTH-1:0] dbg_addr,
  input  logic [31:0]           dbg_wdata,
  output logic                  dbg_ack,
  output logic [31:0]           dbg_rdata,
  output logic                  dbg_rvalid,

  output logic [ADDR_WIDTH-1:0] ram_addr,
  output logic [31:0]           ram_din,
  output logic [3:0]            ram_write_en,
  input  logic [31:0]           ram_dout
);

  state_t      state;
  rd_ctx_t     ctx;
  logic        grant_dbg;
  logic        grant_core;
  logic        core_mis;
  logic        rd_start;
  logic [31:0] ld_data;

  assign core_mis = is_misaligned(core_size, core_addr[1:0]);

  always_comb begin
    grant_dbg  = 1'b0;
    grant_core = 1'b0;
    if (state == ST_IDLE) begin
      if (dbg_req && (DBG_PRIORITY || !core_req))
        grant_dbg = 1'b1;
      else if (core_req)
        grant_core = 1'b1;
    end
  end

  assign core_ack = reset_n & grant_core;
  assign dbg_ack  = reset_n & grant_dbg;

  // Trapped core accesses present nothing to the RAM.
  always_comb begin
    ram_addr     = '0;
    ram_din      = '0;
    ram_write_en = 4'b0000;
    if (grant_dbg) begin
      ram_addr = dbg_addr;
      ram_din  = dbg_wdata;
      if (dbg_we)
        ram_write_en = 4'b1111;
    end else if (grant_core && !core_mis) begin
      ram_addr = core_addr[ADDR_WIDTH+1:2];
      ram_din  = store_data(core_size, core_wdata);
      if (core_we)
        ram_write_en = lane_mask(core_size, core_addr[1:0]);
    end
    if (!reset_n)
      ram_write_en = 4'b0000;
  end

  assign rd_start = (grant_dbg && !dbg_we) || (grant_core && !core_mis && !core_we);

  ram_access_ctrl_load_align u_align (
    .dout        (ram_dout),
    .offset      (ctx.offset),
    .size        (ctx.size),
    .is_unsigned (ctx.uns),
    .data        (ld_data)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state           <= ST_IDLE;
      ctx             <= '0;
      core_rdata      <= '0;
      dbg_rdata       <= '0;
      core_rvalid     <= 1'b0;
      dbg_rvalid      <= 1'b0;
      core_misaligned <= 1'b0;
    end else begin
      core_rvalid     <= 1'b0;
      dbg_rvalid      <= 1'b0;
      core_misaligned <= grant_core & core_mis;
      case (state)
        ST_IDLE: begin
          if (rd_start) begin
            state <= ST_RD_WAIT;
            if (grant_dbg)
              ctx <= '{port: PORT_DBG, size: SIZE_WORD, uns: 1'b1, offset: 2'b00};
            else
              ctx <= '{port: PORT_CORE, size: core_size, uns: core_unsigned,
                       offset: core_addr[1:0]};
          end
        end
        ST_RD_WAIT: begin
          // RAM output now reflects the address sampled at the accept edge.
          state <= ST_IDLE;
          if (ctx.port == PORT_DBG) begin
            dbg_rdata  <= ld_data;
            dbg_rvalid <= 1'b1;
          end else begin
            core_rdata  <= ld_data;
            core_rvalid <= 1'b1;
          end
        end
      endcase
    end
  end

endmodule
